oled_spi_ctrl: RTL and testbench

OLED_SPI_CTRL -- requirements
Module: oled_spi_ctrl

---
 rtl/oled_pkg.sv | 45 ++++
 rtl/oled_init_rom.sv | 17 +
 rtl/oled_spi_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_oled_spi_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared types and constants for the OLED SPI controller
package oled_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_CLR_CMD,
    ST_CLR_DATA,
    ST_DISP_ON,
    ST_IDLE,
    ST_HOST
  } state_e;

  typedef enum logic {
    PH_SEND,
    PH_GAP
  } phase_e;

  localparam int          CS_BIT    = 9;
  localparam int          DC_BIT    = 8;
  localparam logic [9:0]  IDLE_WORD = 10'h200;

  localparam int          INIT_LEN  = 25;
  localparam logic [4:0]  INIT_LAST = 5'd24;

  // Entry 0 sits in the least significant byte; the upper 56 bits pad the
  // table to 32 entries so any 5-bit index selects in range.
  localparam logic [255:0] INIT_TABLE = {
    56'h0,
    8'h14, 8'h8D, 8'h02, 8'h20, 8'h40, 8'hDB, 8'h12, 8'hDA, 8'hF1, 8'hD9,
    8'h80, 8'hD5, 8'h00, 8'hD3, 8'h3F, 8'hA8, 8'hA6, 8'hC8, 8'hA1, 8'hCF,
    8'h81, 8'h40, 8'h10, 8'h00, 8'hAE
  };

  localparam logic [7:0]  CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0]  CMD_COL_LO    = 8'h00;
  localparam logic [7:0]  CMD_COL_HI    = 8'h10;
  localparam logic [7:0]  CMD_DISP_ON   = 8'hAF;
  localparam logic [7:0]  CLR_FILL      = 8'h00;

  localparam logic [2:0]  PAGE_LAST     = 3'd7;
  localparam logic [6:0]  COL_LAST      = 7'd127;
  localparam logic [1:0]  CLR_CMD_LAST  = 2'd2;

endpackage

// File: rtl/oled_init_rom.sv
// rtl/oled_init_rom.sv - combinational lookup of the power-up command list
module oled_init_rom
  import oled_pkg::*;
(
  input  logic [4:0] idx_i,
  output logic [7:0] cmd_o
);

  logic [7:0] bit_sel;

  // Pick one byte out of the packed command table.
  always_comb begin
    bit_sel = {idx_i, 3'b000};
    cmd_o   = INIT_TABLE[bit_sel +: 8];
  end

endmodule

// File: rtl/oled_spi_ctrl.sv
// rtl/oled_spi_ctrl.sv - OLED power-up, screen clear and host byte sequencer
module oled_spi_ctrl
  import oled_pkg::*;
#(
  parameter logic [19:0] PWR_DLY = 20'd100000,
  parameter logic [9:0]  TMO     = 10'd1000
) (
  input  logic       clk_1m,
  input  logic       RST_n,
  output logic       spi_write_start,
  output logic [9:0] spi_data,
  input  logic       spi_write_done,
  input  logic       host_req,
  input  logic       host_dc,
  input  logic [7:0] host_byte,
  output logic       host_ack,
  output logic       ready,
  output logic       err
);

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic        gap_q, gap_d;
  logic [4:0]  idx_q, idx_d;
  logic [2:0]  page_q, page_d;
  logic [6:0]  col_q, col_d;
  logic [19:0] dly_q, dly_d;
  logic [9:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        hdc_q, hdc_d;
  logic [7:0]  hbyte_q, hbyte_d;

  logic [7:0]  rom_cmd;
  logic        cur_dc;
  logic [7:0]  cur_byte;
  logic [9:0]  send_word;

  oled_init_rom u_rom (
    .idx_i (idx_q),
    .cmd_o (rom_cmd)
  );

  // Choose DC and byte for the active sequence step and form the writer word.
  always_comb begin
    cur_dc   = 1'b0;
    cur_byte = 8'h00;
    case (state_q)
      ST_INIT:     cur_byte = rom_cmd;
      ST_CLR_CMD: begin
        case (idx_q[1:0])
          2'd0:    cur_byte = CMD_PAGE_BASE | {5'd0, page_q};
          2'd1:    cur_byte = CMD_COL_LO;
          default: cur_byte = CMD_COL_HI;
        endcase
      end
      ST_CLR_DATA: begin
        cur_dc   = 1'b1;
        cur_byte = CLR_FILL;
      end
      ST_DISP_ON:  cur_byte = CMD_DISP_ON;
      ST_HOST: begin
        cur_dc   = hdc_q;
        cur_byte = hbyte_q;
      end
      default: ;
    endcase
    send_word         = IDLE_WORD;
    send_word[CS_BIT] = 1'b0;
    send_word[DC_BIT] = cur_dc;
    send_word[7:0]    = cur_byte;
  end

  // Next-state logic: top-level sequencing plus the shared SEND/GAP byte engine.
  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    gap_d           = gap_q;
    idx_d           = idx_q;
    page_d          = page_q;
    col_d           = col_q;
    dly_d           = dly_q;
    tmo_d           = tmo_q;
    err_d           = err_q;
    hdc_d           = hdc_q;
    hbyte_d         = hbyte_q;
    spi_write_start = 1'b0;
    spi_data        = IDLE_WORD;
    host_ack        = 1'b0;
    ready           = 1'b0;

    case (state_q)
      ST_PWR_WAIT: begin
        if (dly_q == PWR_DLY - 20'd1) begin
          state_d = ST_INIT;
          phase_d = PH_SEND;
          tmo_d   = 10'd0;
          dly_d   = 20'd0;
        end else begin
          dly_d = dly_q + 20'd1;
        end
      end

      ST_IDLE: begin
        ready = 1'b1;
        if (host_req) begin
          hdc_d   = host_dc;
          hbyte_d = host_byte;
          state_d = ST_HOST;
          phase_d = PH_SEND;
          tmo_d   = 10'd0;
        end
      end

      default: begin
        if (phase_q == PH_SEND) begin
          spi_write_start = 1'b1;
          spi_data        = send_word;
          // Done wins over a timeout landing on the same cycle.
          if (spi_write_done) begin
            phase_d = PH_GAP;
            gap_d   = 1'b0;
            tmo_d   = 10'd0;
          end else if (tmo_q == TMO - 10'd1) begin
            err_d   = 1'b1;
            phase_d = PH_GAP;
            gap_d   = 1'b0;
            tmo_d   = 10'd0;
          end else begin
            tmo_d = tmo_q + 10'd1;
          end
        end else begin
          host_ack = (state_q == ST_HOST) && !gap_q;
          if (!gap_q) begin
            gap_d = 1'b1;
          end else begin
            gap_d   = 1'b0;
            phase_d = PH_SEND;
            tmo_d   = 10'd0;
            case (state_q)
              ST_INIT: begin
                if (idx_q == INIT_LAST) begin
                  idx_d   = 5'd0;
                  state_d = ST_CLR_CMD;
                end else begin
                  idx_d = idx_q + 5'd1;
                end
              end
              ST_CLR_CMD: begin
                if (idx_q[1:0] == CLR_CMD_LAST) begin
                  idx_d   = 5'd0;
                  col_d   = 7'd0;
                  state_d = ST_CLR_DATA;
                end else begin
                  idx_d = idx_q + 5'd1;
                end
              end
              ST_CLR_DATA: begin
                if (col_q == COL_LAST) begin
                  col_d = 7'd0;
                  if (page_q == PAGE_LAST) begin
                    page_d  = 3'd0;
                    state_d = ST_DISP_ON;
                  end else begin
                    page_d  = page_q + 3'd1;
                    state_d = ST_CLR_CMD;
                  end
                end else begin
                  col_d = col_q + 7'd1;
                end
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  assign err = err_q;

  // State and counter registers; reset aborts any transfer and restarts power-up.
  always_ff @(posedge clk_1m or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_PWR_WAIT;
      phase_q <= PH_SEND;
      gap_q   <= 1'b0;
      idx_q   <= 5'd0;
      page_q  <= 3'd0;
      col_q   <= 7'd0;
      dly_q   <= 20'd0;
      tmo_q   <= 10'd0;
      err_q   <= 1'b0;
      hdc_q   <= 1'b0;
      hbyte_q <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      col_q   <= col_d;
      dly_q   <= dly_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      hdc_q   <= hdc_d;
      hbyte_q <= hbyte_d;
    end
  end

endmodule

// File: tb/tb_oled_spi_ctrl.sv
// tb/tb_oled_spi_ctrl.sv - randomized self-checking bench for oled_spi_ctrl
module tb_oled_spi_ctrl;

  localparam logic [19:0] PWR_DLY = 20'd10;
  localparam logic [9:0]  TMO     = 10'd20;
  localparam int          NBYTES  = 1074;

  logic       clk_1m = 1'b0;
  logic       RST_n = 1'b0;
  logic       spi_write_start;
  logic [9:0] spi_data;
  logic       spi_write_done = 1'b0;
  logic       host_req = 1'b0;
  logic       host_dc = 1'b0;
  logic [7:0] host_byte = 8'h00;
  logic       host_ack;
  logic       ready;
  logic       err;

  int checks = 0;
  int errors = 0;
  int wr_mode = -1;
  int hold_bad = 0;
  int ack_cnt = 0;
  logic [9:0] obs[$];
  int gaps[$];
  logic [9:0] exp_seq[NBYTES];
  logic err_exp = 1'b0;

  oled_spi_ctrl #(.PWR_DLY(PWR_DLY), .TMO(TMO)) dut (
    .clk_1m          (clk_1m),
    .RST_n           (RST_n),
    .spi_write_start (spi_write_start),
    .spi_data        (spi_data),
    .spi_write_done  (spi_write_done),
    .host_req        (host_req),
    .host_dc         (host_dc),
    .host_byte       (host_byte),
    .host_ack        (host_ack),
    .ready           (ready),
    .err             (err)
  );

  always #5 clk_1m = ~clk_1m;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] obs_at(input int i);
    if (i < obs.size()) return obs[i];
    return 10'h3FF;
  endfunction

  // Writer model: done pulses a chosen number of cycles into each SEND (0 = never).
  initial begin : writer
    int wcnt;
    int cur_d;
    wcnt = 0;
    cur_d = 1;
    forever begin
      @(negedge clk_1m);
      spi_write_done = 1'b0;
      if (RST_n && spi_write_start) begin
        wcnt++;
        if (wcnt == 1) cur_d = (wr_mode < 0) ? int'($urandom_range(6, 1)) : wr_mode;
        if (cur_d != 0 && wcnt == cur_d) spi_write_done = 1'b1;
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: log each transfer word and the low-time before it; track hold and idle words.
  initial begin : monitor
    logic prev;
    logic [9:0] held;
    int gap;
    prev = 1'b0;
    held = 10'h0;
    gap = 0;
    forever begin
      @(posedge clk_1m);
      #1;
      if (!RST_n) begin
        prev = 1'b0;
        gap = 0;
      end else begin
        if (spi_write_start && !prev) begin
          obs.push_back(spi_data);
          gaps.push_back(gap);
          held = spi_data;
        end else if (spi_write_start && spi_data !== held) begin
          hold_bad++;
        end
        if (!spi_write_start) begin
          gap++;
          if (spi_data !== 10'h200) hold_bad++;
        end else begin
          gap = 0;
        end
        if (host_ack) ack_cnt++;
        prev = spi_write_start;
      end
    end
  end

  task automatic build_expected();
    logic [7:0] init_tab[25];
    int k;
    init_tab = '{8'hAE, 8'h00, 8'h10, 8'h40, 8'h81, 8'hCF, 8'hA1, 8'hC8, 8'hA6,
                 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9, 8'hF1, 8'hDA,
                 8'h12, 8'hDB, 8'h40, 8'h20, 8'h02, 8'h8D, 8'h14};
    k = 0;
    for (int i = 0; i < 25; i++) exp_seq[k++] = {2'b00, init_tab[i]};
    for (int p = 0; p < 8; p++) begin
      exp_seq[k++] = 10'h0B0 + 10'(p);
      exp_seq[k++] = 10'h000;
      exp_seq[k++] = 10'h010;
      for (int c = 0; c < 128; c++) exp_seq[k++] = 10'h100;
    end
    exp_seq[k] = 10'h0AF;
  endtask

  task automatic startup(input bit inject_req);
    int n;
    int mism;
    int gbad;
    obs.delete();
    gaps.delete();
    hold_bad = 0;
    ack_cnt = 0;
    wr_mode = -1;
    @(negedge clk_1m);
    RST_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk_1m);
      #1;
      n++;
    end while (!spi_write_start && n < 100);
    chk("first_send_cyc", n, 10);
    chk("first_word", spi_data, 10'h0AE);
    n = 0;
    while (!ready && n < 20000) begin
      @(posedge clk_1m);
      #1;
      n++;
      if (inject_req && n == 30) begin
        host_req = 1'b1;
        host_dc = 1'b1;
        host_byte = 8'($urandom);
      end
      if (inject_req && n == 34) host_req = 1'b0;
    end
    chk("ready_up", ready, 1);
    chk("byte_count", obs.size(), NBYTES);
    mism = 0;
    for (int i = 0; i < NBYTES; i++) if (obs_at(i) !== exp_seq[i]) mism++;
    chk("seq_mismatches", mism, 0);
    chk("byte26", obs_at(25), 10'h0B0);
    chk("byte27", obs_at(26), 10'h000);
    chk("byte28", obs_at(27), 10'h010);
    chk("byte29", obs_at(28), 10'h100);
    chk("last_byte", obs_at(NBYTES - 1), 10'h0AF);
    gbad = 0;
    for (int i = 1; i < gaps.size(); i++) if (gaps[i] != 2) gbad++;
    chk("gap_len_bad", gbad, 0);
    chk("hold_bad", hold_bad, 0);
    chk("startup_acks", ack_cnt, 0);
    chk("startup_err", err, 0);
  endtask

  task automatic host_xfer(input logic dc, input logic [7:0] b, input int d, input bit keep);
    int n;
    int len;
    host_dc = dc;
    host_byte = b;
    host_req = 1'b1;
    wr_mode = d;
    n = 0;
    do begin
      @(posedge clk_1m);
      #1;
      n++;
    end while (!spi_write_start && n < 50);
    chk("host_lat", n, 1);
    chk("host_word", spi_data, {1'b0, dc, b});
    len = 0;
    while (spi_write_start && len < 100) begin
      len++;
      @(posedge clk_1m);
      #1;
    end
    chk("send_len", len, (d == 0) ? int'(TMO) : d);
    chk("ack_pulse", host_ack, 1);
    chk("ready_in_gap", ready, 0);
    if (!keep) host_req = 1'b0;
    if (d == 0 || d > int'(TMO)) err_exp = 1'b1;
    @(posedge clk_1m);
    #1;
    chk("ack_width", host_ack, 0);
    chk("ready_gap2", ready, 0);
    @(posedge clk_1m);
    #1;
    chk("ready_back", ready, 1);
    chk("host_err", err, err_exp);
  endtask

  initial begin : main
    int n;
    build_expected();
    RST_n = 1'b0;
    repeat (3) @(posedge clk_1m);
    #1;
    chk("rst_start", spi_write_start, 0);
    chk("rst_data", spi_data, 10'h200);
    chk("rst_ack", host_ack, 0);
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);

    startup(1'b1);

    host_xfer(1'b1, 8'h5A, 3, 1'b0);
    for (int i = 0; i < 12; i++)
      host_xfer(1'($urandom), 8'($urandom), int'($urandom_range(int'(TMO), 1)), (i % 3 == 0));
    host_xfer(1'b0, 8'h81, int'(TMO), 1'b0);
    chk("err_at_tmo_boundary", err, 0);
    host_xfer(1'b1, 8'hC3, 0, 1'b0);
    chk("err_after_timeout", err, 1);
    host_xfer(1'b0, 8'h3C, 2, 1'b0);
    chk("err_sticky", err, 1);
    repeat (5) @(posedge clk_1m);
    #1;
    chk("no_extra_xfer", spi_write_start, 0);
    chk("idle_ready", ready, 1);

    RST_n = 1'b0;
    #1;
    chk("err_cleared", err, 0);
    obs.delete();
    wr_mode = 6;
    @(negedge clk_1m);
    RST_n = 1'b1;
    n = 0;
    while (obs.size() < 93 && n < 5000) begin
      @(posedge clk_1m);
      #1;
      n++;
    end
    chk("reach_col64", obs.size(), 93);
    chk("pre_rst_start", spi_write_start, 1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("mid_rst_start", spi_write_start, 0);
    chk("mid_rst_data", spi_data, 10'h200);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_ack", host_ack, 0);
    repeat (2) @(posedge clk_1m);
    startup(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
